// File: rtl/specu_flush_ctrl_pkg.sv
// Shared ROB sizing, FSM encodings and one-hot helpers for the speculative-flush controller.
`ifndef REORDER_BUFFER_SIZE
`define REORDER_BUFFER_SIZE 16
`endif

package specu_flush_ctrl_pkg;

   localparam int ROB_SIZE = `REORDER_BUFFER_SIZE;
   localparam int IDX_W    = $clog2(ROB_SIZE);
   localparam int CNT_W    = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FLUSH   = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   typedef logic [ROB_SIZE-1:0] rob_vec_t;

   // Priority encoder; the lowest set bit wins, so a stray multi-hot input still gives a defined index.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input rob_vec_t v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = ROB_SIZE - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic rob_vec_t rotl1(input rob_vec_t v);
      return {v[ROB_SIZE-2:0], v[ROB_SIZE-1]};
   endfunction

endpackage

// File: rtl/specu_flush_ctrl_head_below_mask_gen.sv
// Combinational one-hot to "strictly below" thermometer: bit i is set when the hot bit sits above i.
module head_below_mask_gen
   import specu_flush_ctrl_pkg::*;
(
   input  logic [ROB_SIZE-1:0] onehot,
   output logic [ROB_SIZE-1:0] below
);

   logic seen;

   always_comb begin
      below = '0;
      seen  = 1'b0;
      for (int i = ROB_SIZE - 1; i >= 0; i--) begin
         below[i] = seen;
         seen     = seen | onehot[i];
      end
   end

endmodule

// File: rtl/specu_flush_ctrl.sv
// ROB speculative-flush controller: kills entries younger than a mispredicted branch, rewinds tail, stalls dispatch.
// Optional saturating flush-event counter is built when SPECU_FLUSH_STATS_EN is defined.
module specu_flush_ctrl
   import specu_flush_ctrl_pkg::*;
#(
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                alloc_valid,
   input  logic [ROB_SIZE-1:0] alloc_onehot,
   input  logic                commit_valid,
   input  logic                branch_resolve_valid,
   input  logic                branch_mispredict,
   input  logic [ROB_SIZE-1:0] branch_tag_onehot,
   input  logic [ROB_SIZE-1:0] keep_mask_in,
   output logic [ROB_SIZE-1:0] entry_valid,
   output logic [ROB_SIZE-1:0] head_onehot,
   output logic                rob_full,
   output logic                flush_pulse,
   output logic [ROB_SIZE-1:0] flush_mask,
   output logic [ROB_SIZE-1:0] tail_rewind_onehot,
   output logic                dispatch_stall,
   output logic [15:0]         flush_count
);

   logic [1:0]       state;
   logic [CNT_W-1:0] rec_cnt;

   rob_vec_t below_head;
   rob_vec_t span;
   rob_vec_t survivors;
   rob_vec_t alloc_set;
   rob_vec_t commit_clr;
   rob_vec_t flush_clr;
   rob_vec_t valid_alloc;
   logic     accept;
   logic     head_le_branch;

   head_below_mask_gen u_below (
      .onehot (head_onehot),
      .below  (below_head)
   );

   always_comb begin
      alloc_set  = (state == ST_IDLE && alloc_valid && (alloc_onehot & entry_valid) == '0)
                   ? alloc_onehot : '0;
      commit_clr = (commit_valid && (head_onehot & entry_valid) != '0) ? head_onehot : '0;
      flush_clr  = (state == ST_FLUSH) ? flush_mask : '0;
      accept     = branch_resolve_valid && branch_mispredict &&
                   (branch_tag_onehot & entry_valid) != '0 &&
                   (state == ST_IDLE || state == ST_RECOVER);
      // Survivors are the head..branch window; it wraps past entry 15 when the head is above the branch.
      span           = keep_mask_in | branch_tag_onehot;
      head_le_branch = onehot_to_idx(head_onehot) <= onehot_to_idx(branch_tag_onehot);
      survivors      = head_le_branch ? (span & ~below_head) : (span | ~below_head);
      valid_alloc    = entry_valid | alloc_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entry_valid        <= '0;
         head_onehot        <= rob_vec_t'(1);
         flush_pulse        <= 1'b0;
         flush_mask         <= '0;
         tail_rewind_onehot <= '0;
      end else begin
         entry_valid        <= valid_alloc & ~commit_clr & ~flush_clr;
         if (commit_clr != '0) head_onehot <= rotl1(head_onehot);
         flush_pulse        <= accept;
         flush_mask         <= accept ? (valid_alloc & ~survivors) : '0;
         tail_rewind_onehot <= accept ? rotl1(branch_tag_onehot) : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         rec_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               state   <= ST_RECOVER;
               rec_cnt <= CNT_W'(RECOVER_CYCLES);
            end
            ST_RECOVER: begin
               if (accept) begin
                  state   <= ST_FLUSH;
                  rec_cnt <= '0;
               end else if (rec_cnt <= CNT_W'(1)) begin
                  state   <= ST_IDLE;
                  rec_cnt <= '0;
               end else begin
                  rec_cnt <= rec_cnt - CNT_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               rec_cnt <= '0;
            end
         endcase
      end
   end

   assign rob_full       = &entry_valid;
   assign dispatch_stall = (state != ST_IDLE);

`ifdef SPECU_FLUSH_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_count <= '0;
      end else if (state == ST_FLUSH && flush_count != 16'hFFFF) begin
         flush_count <= flush_count + 16'd1;
      end
   end
`else
   assign flush_count = '0;
`endif

endmodule
